// File: rtl/div_32_seq.sv
// div_32_seq: multi-cycle restoring divider for MIPS DIV/DIVU.
// One (WIDTH+1)-bit trial subtraction per clock; quotient feeds LO, remainder feeds HI.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, is_signed    request (sampled only when idle), 1 = DIV, 0 = DIVU
//   dividend, divisor   operands, captured on the accepting edge
//   busy                high while an operation is in flight (PREP, CALC, FIX)
//   done                one-cycle pulse, results valid
//   quotient, remainder registered results, held until the next operation finishes
//   div_by_zero         divisor of the current result was zero
module div_32_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] dvd_q;      // raw captured dividend
  logic [WIDTH-1:0] dvs_q;      // raw captured divisor
  logic             sgn_q;
  logic [WIDTH-1:0] dvs_mag_q;  // |divisor| used by the iteration
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;      // starts as |dividend|, shifts out as quotient shifts in
  logic             q_neg_q;
  logic             r_neg_q;
  logic [CntW-1:0]  count_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             dbz;

  always_comb begin
    // Shift the next dividend bit into the partial remainder, then trial-subtract.
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, dvs_mag_q};
    borrow  = trial[WIDTH];

    dvd_mag = (sgn_q && dvd_q[WIDTH-1]) ? (~dvd_q + 1'b1) : dvd_q;
    dvs_mag = (sgn_q && dvs_q[WIDTH-1]) ? (~dvs_q + 1'b1) : dvs_q;

    dbz     = (dvs_q == '0);
    q_fix   = q_neg_q ? (~quo_q + 1'b1) : quo_q;
    r_fix   = r_neg_q ? (~rem_q + 1'b1) : rem_q;
    if (dbz) begin
      q_fix = '1;
      r_fix = dvd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dvd_q       <= '0;
      dvs_q       <= '0;
      sgn_q       <= 1'b0;
      dvs_mag_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            sgn_q   <= is_signed;
            busy_q  <= 1'b1;
            state_q <= StPrep;
          end
        end
        StPrep: begin
          quo_q     <= dvd_mag;
          dvs_mag_q <= dvs_mag;
          q_neg_q   <= sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          r_neg_q   <= sgn_q & dvd_q[WIDTH-1];
          rem_q     <= '0;
          count_q   <= '0;
          state_q   <= StCalc;
        end
        StCalc: begin
          rem_q   <= borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_q   <= {quo_q[WIDTH-2:0], ~borrow};
          count_q <= count_q + CntW'(1);
          if (count_q == CntW'(WIDTH - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          quotient_q  <= q_fix;
          remainder_q <= r_fix;
          dbz_q       <= dbz;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
